squash_arbiter: RTL and testbench

- Collects mispredict reports from the branch writeback ports and memory-order violation reports from the load pipes.
- Keeps only the oldest outstanding squash candidate, ordered by robIdx age.
- Issues one squashInfo_t pulse when the ROB retires that instruction, so branch/violation squashes are generated only at retire.
- Sits between the execute writeback network and the ROB/FTQ/frontend redirect logic.

---
 rtl/squash_arbiter.sv | 155 +++++++++++++++
 tb/tb_squash_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/squash_arbiter.sv
// Holds the oldest outstanding branch-mispredict / memory-order-violation candidate
// and emits a single squash pulse when the ROB retires that instruction.
module squash_arbiter #(
    parameter  int BRU_PORTS           = 2,
    parameter  int LDU_PORTS           = 2,
    parameter  int ROB_DEPTH           = 64,
    parameter  int XLEN                = 32,
    parameter  int MEMDEP_FOLDPC_WIDTH = 8,
    localparam int IDX_W = $clog2(ROB_DEPTH),
    localparam int ROB_W = IDX_W + 1,
    localparam int FW    = MEMDEP_FOLDPC_WIDTH,
    // branchwbInfo_t : {rob_idx, has_mispred, branch_taken, target_pc, branch_npc}
    localparam int BWB_W = ROB_W + 2 + 2 * XLEN,
    // squashInfo_t   : {rob_idx, dueToBranch, dueToViolation, branch_taken, arch_pc, load_foldpc, store_foldpc}
    localparam int SQ_W  = ROB_W + 3 + XLEN + 2 * FW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BRU_PORTS-1:0]         i_bwb_vld,
    input  logic [BRU_PORTS*BWB_W-1:0]   i_bwb_info,
    input  logic [LDU_PORTS-1:0]         i_vio_vld,
    input  logic [LDU_PORTS*ROB_W-1:0]   i_vio_robIdx,
    input  logic [LDU_PORTS*XLEN-1:0]    i_vio_pc,
    input  logic [LDU_PORTS*FW-1:0]      i_vio_ld_foldpc,
    input  logic [LDU_PORTS*FW-1:0]      i_vio_st_foldpc,
    input  logic                         i_commit_vld,
    input  logic [ROB_W-1:0]             i_commit_robIdx,
    input  logic                         i_flush,
    output logic                         o_pend_vld,
    output logic [ROB_W-1:0]             o_pend_robIdx,
    output logic                         o_squash_vld,
    output logic [SQ_W-1:0]              o_squash
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SQ_W-1:0]   hold_q, hold_d;
    logic              pend_vld_q, pend_vld_d;
    logic              squash_vld_q, squash_vld_d;
    logic [SQ_W-1:0]   squash_q, squash_d;

    logic              cand_vld_s;
    logic [SQ_W-1:0]   cand_s;
    logic [BWB_W-1:0]  bwb_s;
    logic [ROB_W-1:0]  hold_rob_s;

    // The flag bit flips on every ROB wrap, so a differing flag inverts the index order.
    function automatic logic is_older(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
        if (a[ROB_W-1] == b[ROB_W-1]) begin
            is_older = (a[IDX_W-1:0] < b[IDX_W-1:0]);
        end else begin
            is_older = (a[IDX_W-1:0] > b[IDX_W-1:0]);
        end
    endfunction

    assign hold_rob_s = hold_q[SQ_W-1 -: ROB_W];

    // Oldest-candidate selection; violation ports scan first so they win robIdx ties.
    always_comb begin
        cand_vld_s = 1'b0;
        cand_s     = '0;
        bwb_s      = '0;
        for (int p = 0; p < LDU_PORTS; p++) begin
            if (i_vio_vld[p] &&
                (!cand_vld_s || is_older(i_vio_robIdx[p*ROB_W +: ROB_W], cand_s[SQ_W-1 -: ROB_W]))) begin
                cand_vld_s = 1'b1;
                cand_s     = {i_vio_robIdx[p*ROB_W +: ROB_W], 1'b0, 1'b1, 1'b0,
                              i_vio_pc[p*XLEN +: XLEN],
                              i_vio_ld_foldpc[p*FW +: FW], i_vio_st_foldpc[p*FW +: FW]};
            end else begin
                cand_vld_s = cand_vld_s;
            end
        end
        for (int p = 0; p < BRU_PORTS; p++) begin
            bwb_s = i_bwb_info[p*BWB_W +: BWB_W];
            if (i_bwb_vld[p] && bwb_s[2*XLEN+1] &&
                (!cand_vld_s || is_older(bwb_s[BWB_W-1 -: ROB_W], cand_s[SQ_W-1 -: ROB_W]))) begin
                cand_vld_s = 1'b1;
                cand_s     = {bwb_s[BWB_W-1 -: ROB_W], 1'b1, 1'b0, bwb_s[2*XLEN],
                              bwb_s[2*XLEN] ? bwb_s[2*XLEN-1 -: XLEN] : bwb_s[XLEN-1:0],
                              {FW{1'b0}}, {FW{1'b0}}};
            end else begin
                cand_vld_s = cand_vld_s;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        squash_vld_d = 1'b0;
        squash_d     = '0;
        case (state_q)
            IDLE: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else if (cand_vld_s) begin
                    hold_d  = cand_s;
                    state_d = PEND;
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else if (i_commit_vld && (i_commit_robIdx == hold_rob_s)) begin
                    state_d      = SQUASH;
                    squash_vld_d = 1'b1;
                    squash_d     = hold_q;
                end else if (cand_vld_s && is_older(cand_s[SQ_W-1 -: ROB_W], hold_rob_s)) begin
                    hold_d = cand_s;
                end else begin
                    hold_d = hold_q;
                end
            end
            SQUASH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pend_vld_d = (state_d == PEND);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            pend_vld_q   <= 1'b0;
            squash_vld_q <= 1'b0;
            squash_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            pend_vld_q   <= pend_vld_d;
            squash_vld_q <= squash_vld_d;
            squash_q     <= squash_d;
        end
    end

    assign o_pend_vld    = pend_vld_q;
    assign o_pend_robIdx = hold_rob_s;
    assign o_squash_vld  = squash_vld_q;
    assign o_squash      = squash_q;

endmodule

// File: tb/tb_squash_arbiter.sv
// Directed bench for squash_arbiter; expected squash payloads queue up when the
// matching commit is driven and are popped when the pulse appears.
module tb_squash_arbiter;

    localparam int BRU   = 2;
    localparam int LDU   = 2;
    localparam int ROB_W = 7;
    localparam int XLEN  = 32;
    localparam int FW    = 8;
    localparam int BWB_W = ROB_W + 2 + 2 * XLEN;
    localparam int SQ_W  = ROB_W + 3 + XLEN + 2 * FW;

    logic                   clk;
    logic                   rst;
    logic [BRU-1:0]         i_bwb_vld;
    logic [BRU*BWB_W-1:0]   i_bwb_info;
    logic [LDU-1:0]         i_vio_vld;
    logic [LDU*ROB_W-1:0]   i_vio_robIdx;
    logic [LDU*XLEN-1:0]    i_vio_pc;
    logic [LDU*FW-1:0]      i_vio_ld_foldpc;
    logic [LDU*FW-1:0]      i_vio_st_foldpc;
    logic                   i_commit_vld;
    logic [ROB_W-1:0]       i_commit_robIdx;
    logic                   i_flush;
    logic                   o_pend_vld;
    logic [ROB_W-1:0]       o_pend_robIdx;
    logic                   o_squash_vld;
    logic [SQ_W-1:0]        o_squash;

    int n_cmp = 0;
    int n_err = 0;
    logic [SQ_W-1:0] sb[$];

    squash_arbiter #(
        .BRU_PORTS(BRU), .LDU_PORTS(LDU), .ROB_DEPTH(64),
        .XLEN(XLEN), .MEMDEP_FOLDPC_WIDTH(FW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_bwb_vld(i_bwb_vld), .i_bwb_info(i_bwb_info),
        .i_vio_vld(i_vio_vld), .i_vio_robIdx(i_vio_robIdx), .i_vio_pc(i_vio_pc),
        .i_vio_ld_foldpc(i_vio_ld_foldpc), .i_vio_st_foldpc(i_vio_st_foldpc),
        .i_commit_vld(i_commit_vld), .i_commit_robIdx(i_commit_robIdx),
        .i_flush(i_flush),
        .o_pend_vld(o_pend_vld), .o_pend_robIdx(o_pend_robIdx),
        .o_squash_vld(o_squash_vld), .o_squash(o_squash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ROB_W-1:0] rb(input logic f, input int i);
        logic [5:0] idx;
        idx = i[5:0];
        return {f, idx};
    endfunction

    function automatic logic [SQ_W-1:0] sq(input logic [ROB_W-1:0] r, input logic b, input logic v,
                                           input logic t, input logic [31:0] pc,
                                           input logic [7:0] ld, input logic [7:0] st);
        return {r, b, v, t, pc, ld, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        i_bwb_vld       = '0;
        i_bwb_info      = '0;
        i_vio_vld       = '0;
        i_vio_robIdx    = '0;
        i_vio_pc        = '0;
        i_vio_ld_foldpc = '0;
        i_vio_st_foldpc = '0;
        i_commit_vld    = 1'b0;
        i_commit_robIdx = '0;
        i_flush         = 1'b0;
    endtask

    task automatic set_bwb(input int p, input logic [ROB_W-1:0] r, input logic mis, input logic tk,
                           input logic [31:0] tgt, input logic [31:0] npc);
        i_bwb_vld[p] = 1'b1;
        i_bwb_info[p*BWB_W +: BWB_W] = {r, mis, tk, tgt, npc};
    endtask

    task automatic set_vio(input int p, input logic [ROB_W-1:0] r, input logic [31:0] pc,
                           input logic [7:0] ld, input logic [7:0] st);
        i_vio_vld[p] = 1'b1;
        i_vio_robIdx[p*ROB_W +: ROB_W] = r;
        i_vio_pc[p*XLEN +: XLEN] = pc;
        i_vio_ld_foldpc[p*FW +: FW] = ld;
        i_vio_st_foldpc[p*FW +: FW] = st;
    endtask

    task automatic commit_expect(input logic [ROB_W-1:0] r, input logic [SQ_W-1:0] exp);
        i_commit_vld    = 1'b1;
        i_commit_robIdx = r;
        sb.push_back(exp);
    endtask

    task automatic check_squash();
        chk("squash_vld", {63'd0, o_squash_vld}, 64'd1);
        chk("pend_in_squash", {63'd0, o_pend_vld}, 64'd0);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_underflow: observed pulse expected none");
        end else begin
            chk("squash_payload", {6'd0, o_squash}, {6'd0, sb.pop_front()});
        end
    endtask

    task automatic check_done();
        chk("squash_vld_fall", {63'd0, o_squash_vld}, 64'd0);
        chk("squash_clear", {6'd0, o_squash}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        tick();
        tick();
        chk("rst_pend_vld", {63'd0, o_pend_vld}, 64'd0);
        chk("rst_pend_rob", {57'd0, o_pend_robIdx}, 64'd0);
        chk("rst_squash_vld", {63'd0, o_squash_vld}, 64'd0);
        chk("rst_squash", {6'd0, o_squash}, 64'd0);
        rst = 1'b0;
        tick();

        // single taken mispredict
        set_bwb(0, rb(1'b0, 5), 1'b1, 1'b1, 32'h8000_1000, 32'h8000_0004);
        tick();
        chk("t1_pend_vld", {63'd0, o_pend_vld}, 64'd1);
        chk("t1_pend_rob", {57'd0, o_pend_robIdx}, {57'd0, rb(1'b0, 5)});
        clear_in();
        commit_expect(rb(1'b0, 5), sq(rb(1'b0, 5), 1'b1, 1'b0, 1'b1, 32'h8000_1000, 8'h00, 8'h00));
        tick();
        check_squash();
        clear_in();
        tick();
        check_done();
        chk("t1_pend_after", {63'd0, o_pend_vld}, 64'd0);

        // non-mispredicted writeback has no effect
        set_bwb(0, rb(1'b0, 30), 1'b0, 1'b1, 32'h8000_0300, 32'h8000_0304);
        tick();
        chk("nomis_pend", {63'd0, o_pend_vld}, 64'd0);
        clear_in();

        // not-taken mispredict, with a non-matching commit first
        set_bwb(1, rb(1'b0, 6), 1'b1, 1'b0, 32'h8000_2000, 32'h8000_0044);
        tick();
        chk("t2_pend_rob", {57'd0, o_pend_robIdx}, {57'd0, rb(1'b0, 6)});
        clear_in();
        i_commit_vld    = 1'b1;
        i_commit_robIdx = rb(1'b0, 7);
        tick();
        chk("t2_other_commit_vld", {63'd0, o_squash_vld}, 64'd0);
        chk("t2_other_commit_pend", {63'd0, o_pend_vld}, 64'd1);
        commit_expect(rb(1'b0, 6), sq(rb(1'b0, 6), 1'b1, 1'b0, 1'b0, 32'h8000_0044, 8'h00, 8'h00));
        tick();
        check_squash();
        clear_in();
        tick();
        check_done();

        // wrap: {0,62} held, younger violation {1,2} ignored
        set_bwb(0, rb(1'b0, 62), 1'b1, 1'b1, 32'h8000_0100, 32'h8000_0200);
        tick();
        clear_in();
        set_vio(0, rb(1'b1, 2), 32'h8000_3000, 8'h11, 8'h22);
        tick();
        chk("wrapA_pend_rob", {57'd0, o_pend_robIdx}, {57'd0, rb(1'b0, 62)});
        clear_in();
        commit_expect(rb(1'b0, 62), sq(rb(1'b0, 62), 1'b1, 1'b0, 1'b1, 32'h8000_0100, 8'h00, 8'h00));
        tick();
        check_squash();
        clear_in();
        tick();
        check_done();

        // wrap: {1,2} held, older branch {0,62} replaces it
        set_vio(0, rb(1'b1, 2), 32'h8000_3000, 8'h11, 8'h22);
        tick();
        chk("wrapB_pend_rob0", {57'd0, o_pend_robIdx}, {57'd0, rb(1'b1, 2)});
        clear_in();
        set_bwb(0, rb(1'b0, 62), 1'b1, 1'b0, 32'h8000_0100, 32'h8000_0200);
        tick();
        chk("wrapB_pend_rob1", {57'd0, o_pend_robIdx}, {57'd0, rb(1'b0, 62)});
        clear_in();
        commit_expect(rb(1'b0, 62), sq(rb(1'b0, 62), 1'b1, 1'b0, 1'b0, 32'h8000_0200, 8'h00, 8'h00));
        tick();
        check_squash();
        clear_in();
        tick();
        check_done();

        // same-cycle multiport: violation wins the {0,7} tie
        set_bwb(0, rb(1'b0, 9), 1'b1, 1'b1, 32'h8000_5000, 32'h8000_5004);
        set_bwb(1, rb(1'b0, 7), 1'b1, 1'b1, 32'h8000_6000, 32'h8000_6004);
        set_vio(0, rb(1'b0, 7), 32'h8000_4000, 8'h5a, 8'ha5);
        tick();
        chk("multi_pend_rob", {57'd0, o_pend_robIdx}, {57'd0, rb(1'b0, 7)});
        clear_in();
        commit_expect(rb(1'b0, 7), sq(rb(1'b0, 7), 1'b0, 1'b1, 1'b0, 32'h8000_4000, 8'h5a, 8'ha5));
        tick();
        check_squash();
        clear_in();
        tick();
        check_done();

        // flush drops the held candidate and same-cycle inputs
        set_bwb(0, rb(1'b0, 3), 1'b1, 1'b1, 32'h8000_7000, 32'h8000_7004);
        tick();
        chk("flush_pend_before", {63'd0, o_pend_vld}, 64'd1);
        clear_in();
        i_flush = 1'b1;
        set_bwb(1, rb(1'b0, 1), 1'b1, 1'b1, 32'h8000_7100, 32'h8000_7104);
        tick();
        chk("flush_pend_after", {63'd0, o_pend_vld}, 64'd0);
        clear_in();
        i_commit_vld    = 1'b1;
        i_commit_robIdx = rb(1'b0, 3);
        tick();
        chk("flush_commit_held", {63'd0, o_squash_vld}, 64'd0);
        i_commit_robIdx = rb(1'b0, 1);
        tick();
        chk("flush_commit_dropped", {63'd0, o_squash_vld}, 64'd0);
        chk("flush_pend_idle", {63'd0, o_pend_vld}, 64'd0);
        clear_in();

        // candidates in the commit-match and SQUASH cycles are dropped
        set_bwb(0, rb(1'b0, 10), 1'b1, 1'b1, 32'h8000_8000, 32'h8000_8004);
        tick();
        clear_in();
        commit_expect(rb(1'b0, 10), sq(rb(1'b0, 10), 1'b1, 1'b0, 1'b1, 32'h8000_8000, 8'h00, 8'h00));
        set_bwb(1, rb(1'b0, 8), 1'b1, 1'b1, 32'h8000_9000, 32'h8000_9004);
        tick();
        check_squash();
        clear_in();
        set_vio(0, rb(1'b0, 4), 32'h8000_a000, 8'h33, 8'h44);
        i_flush = 1'b1;
        tick();
        check_done();
        chk("drop_pend0", {63'd0, o_pend_vld}, 64'd0);
        clear_in();
        tick();
        chk("drop_pend1", {63'd0, o_pend_vld}, 64'd0);

        // asynchronous reset while PEND
        set_bwb(0, rb(1'b0, 20), 1'b1, 1'b1, 32'h8000_b000, 32'h8000_b004);
        tick();
        chk("rstp_pend_before", {63'd0, o_pend_vld}, 64'd1);
        clear_in();
        #2;
        rst = 1'b1;
        #1;
        chk("rstp_pend_vld", {63'd0, o_pend_vld}, 64'd0);
        chk("rstp_pend_rob", {57'd0, o_pend_robIdx}, 64'd0);
        chk("rstp_squash_vld", {63'd0, o_squash_vld}, 64'd0);
        chk("rstp_squash", {6'd0, o_squash}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstp_pend_idle", {63'd0, o_pend_vld}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
